// File: rtl/spi_master_engine_if.sv
// Bridge-facing handshake and SPI pin bundle for spi_master_engine.
// The slave modport is the engine's view; master is the bridge/pad side.
interface spi_master_engine_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  go_transfer;
    logic [DATA_WIDTH-1:0] data_write_to_spi;
    logic [DATA_WIDTH-1:0] data_read_from_spi;
    logic                  transfer_complete;
    logic                  spi_sclk;
    logic                  spi_mosi;
    logic                  spi_miso;
    logic                  spi_cs_n;

    modport slave (
        input  go_transfer, data_write_to_spi, spi_miso,
        output data_read_from_spi, transfer_complete, spi_sclk, spi_mosi, spi_cs_n
    );

    modport master (
        output go_transfer, data_write_to_spi, spi_miso,
        input  data_read_from_spi, transfer_complete, spi_sclk, spi_mosi, spi_cs_n
    );
endinterface

// File: rtl/spi_master_engine.sv
// Mode-0, MSB-first full-duplex SPI shift engine answering the bridge's
// go/complete handshake with one frame per 0->1 edge of go_transfer.
module spi_master_engine #(
    parameter int DATA_WIDTH      = 32,
    parameter int CLK_DIV         = 4,
    parameter int COMPLETE_CYCLES = 2
) (
    input  logic                clk,
    input  logic                reset_n,
    spi_master_engine_if.slave  bus
);
    localparam int CNT_MAX = (CLK_DIV > COMPLETE_CYCLES) ? CLK_DIV : COMPLETE_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int H_W     = $clog2(2 * DATA_WIDTH);

    localparam logic [CNT_W-1:0] CNT_SETUP = CNT_W'(CLK_DIV);
    localparam logic [CNT_W-1:0] CNT_HALF  = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_DONE  = CNT_W'(COMPLETE_CYCLES - 1);
    localparam logic [H_W-1:0]   H_LAST    = H_W'(2 * DATA_WIDTH - 1);

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, DONE} state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [H_W-1:0]        h_q, h_d;
    logic [DATA_WIDTH-1:0] tx_q, tx_d;
    logic [DATA_WIDTH-1:0] rx_q, rx_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  go_q, go_d;
    logic                  sclk_q, sclk_d;
    logic                  mosi_q, mosi_d;
    logic                  cs_n_q, cs_n_d;
    logic                  tc_q, tc_d;
    logic                  start;
    logic [H_W-1:0]        h_nxt;

    assign start = bus.go_transfer & ~go_q;
    assign h_nxt = h_q + H_W'(1);

    // SETUP is loaded with CLK_DIV (not CLK_DIV-1): outputs change on the
    // transition edge, so cs_n falls one edge after the start is sampled.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        h_d     = h_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        rdata_d = rdata_q;
        go_d    = bus.go_transfer;
        sclk_d  = sclk_q;
        mosi_d  = mosi_q;
        cs_n_d  = cs_n_q;
        tc_d    = tc_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    tx_d    = bus.data_write_to_spi;
                    rx_d    = '0;
                    mosi_d  = bus.data_write_to_spi[DATA_WIDTH-1];
                    cnt_d   = CNT_SETUP;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                cs_n_d = 1'b0;
                if (cnt_q == '0) begin
                    h_d     = '0;
                    cnt_d   = CNT_HALF;
                    state_d = SHIFT;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            SHIFT: begin
                if (cnt_q == '0) begin
                    cnt_d = CNT_HALF;
                    if (h_q == H_LAST) begin
                        sclk_d  = 1'b0;
                        state_d = HOLD;
                    end else begin
                        h_d    = h_nxt;
                        sclk_d = h_nxt[0];
                        // Odd index is the rising edge: sample; even index is falling: advance MOSI.
                        if (h_nxt[0]) begin
                            rx_d = {rx_q[DATA_WIDTH-2:0], bus.spi_miso};
                        end else begin
                            tx_d   = tx_q << 1;
                            mosi_d = tx_q[DATA_WIDTH-2];
                        end
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            HOLD: begin
                if (cnt_q == '0) begin
                    cs_n_d  = 1'b1;
                    tc_d    = 1'b1;
                    rdata_d = rx_q;
                    cnt_d   = CNT_DONE;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DONE: begin
                if (cnt_q == '0) begin
                    tc_d    = 1'b0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            h_q     <= '0;
            tx_q    <= '0;
            rx_q    <= '0;
            rdata_q <= '0;
            go_q    <= 1'b0;
            sclk_q  <= 1'b0;
            mosi_q  <= 1'b0;
            cs_n_q  <= 1'b1;
            tc_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            h_q     <= h_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            rdata_q <= rdata_d;
            go_q    <= go_d;
            sclk_q  <= sclk_d;
            mosi_q  <= mosi_d;
            cs_n_q  <= cs_n_d;
            tc_q    <= tc_d;
        end
    end

    assign bus.spi_sclk           = sclk_q;
    assign bus.spi_mosi           = mosi_q;
    assign bus.spi_cs_n           = cs_n_q;
    assign bus.transfer_complete  = tc_q;
    assign bus.data_read_from_spi = rdata_q;
endmodule

// File: tb/tb_spi_master_engine.sv
// Directed bench for spi_master_engine: default 32-bit/CLK_DIV=4 instance
// plus an 8-bit/CLK_DIV=1 instance, both observed at the falling clock edge.
module tb_spi_master_engine;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    int   e_cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    spi_master_engine_if #(.DATA_WIDTH(32)) ifa ();
    spi_master_engine_if #(.DATA_WIDTH(8))  ifb ();

    logic loop_a = 1'b1;
    logic miso_val_a = 1'b0;
    assign ifa.spi_miso = loop_a ? ifa.spi_mosi : miso_val_a;
    assign ifb.spi_miso = ifb.spi_mosi;

    spi_master_engine #(.DATA_WIDTH(32), .CLK_DIV(4), .COMPLETE_CYCLES(2)) dut_a (
        .clk(clk), .reset_n(reset_n), .bus(ifa.slave)
    );
    spi_master_engine #(.DATA_WIDTH(8), .CLK_DIV(1), .COMPLETE_CYCLES(2)) dut_b (
        .clk(clk), .reset_n(reset_n), .bus(ifb.slave)
    );

    int rises_a = 0, cs_falls_a = 0, tc_rises_a = 0, tc_high_a = 0, tc_rise_cyc_a = 0;
    int rises_b = 0, tc_rises_b = 0, tc_rise_cyc_b = 0;
    logic [31:0] mosi_cap_a = '0;
    logic sclk_p_a = 1'b0, cs_p_a = 1'b1, tc_p_a = 1'b0;
    logic sclk_p_b = 1'b0, tc_p_b = 1'b0;

    always @(negedge clk) begin
        if (ifa.spi_sclk && !sclk_p_a) begin
            rises_a    <= rises_a + 1;
            mosi_cap_a <= {mosi_cap_a[30:0], ifa.spi_mosi};
        end
        if (!ifa.spi_cs_n && cs_p_a) cs_falls_a <= cs_falls_a + 1;
        if (ifa.transfer_complete && !tc_p_a) begin
            tc_rises_a    <= tc_rises_a + 1;
            tc_rise_cyc_a <= cyc;
        end
        if (ifa.transfer_complete) tc_high_a <= tc_high_a + 1;
        sclk_p_a <= ifa.spi_sclk;
        cs_p_a   <= ifa.spi_cs_n;
        tc_p_a   <= ifa.transfer_complete;
    end

    always @(negedge clk) begin
        if (ifb.spi_sclk && !sclk_p_b) rises_b <= rises_b + 1;
        if (ifb.transfer_complete && !tc_p_b) begin
            tc_rises_b    <= tc_rises_b + 1;
            tc_rise_cyc_b <= cyc;
        end
        sclk_p_b <= ifb.spi_sclk;
        tc_p_b   <= ifb.transfer_complete;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Raises go right after a clock edge; the following edge is E.
    task automatic start(input int sel, input logic [31:0] tx, input int hold);
        @(posedge clk);
        #1;
        if (sel == 0) begin
            ifa.data_write_to_spi = tx;
            ifa.go_transfer       = 1'b1;
        end else begin
            ifb.data_write_to_spi = tx[7:0];
            ifb.go_transfer       = 1'b1;
        end
        e_cyc = cyc + 1;
        repeat (hold) @(posedge clk);
        #1;
        if (sel == 0) ifa.go_transfer = 1'b0;
        else          ifb.go_transfer = 1'b0;
    endtask

    task automatic wait_tc(input int sel, input int base, input int budget);
        int n = 0;
        while (((sel == 0) ? tc_rises_a : tc_rises_b) == base && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("tc_seen", 32'(((sel == 0) ? tc_rises_a : tc_rises_b) != base), 32'd1);
    endtask

    initial begin
        int b_r, b_cs, b_tc, b_hi, e1, n;
        ifa.go_transfer = 1'b0;
        ifa.data_write_to_spi = '0;
        ifb.go_transfer = 1'b0;
        ifb.data_write_to_spi = '0;
        repeat (4) @(posedge clk);
        #1;
        check("rst_sclk", 32'(ifa.spi_sclk), 32'd0);
        check("rst_cs_n", 32'(ifa.spi_cs_n), 32'd1);
        check("rst_mosi", 32'(ifa.spi_mosi), 32'd0);
        check("rst_rdata", ifa.data_read_from_spi, 32'd0);
        check("rst_tc", 32'(ifa.transfer_complete), 32'd0);
        reset_n = 1'b1;
        repeat (3) @(posedge clk);

        // Loopback, 7-cycle go pulse
        b_r = rises_a; b_cs = cs_falls_a; b_tc = tc_rises_a; b_hi = tc_high_a;
        start(0, 32'hA5A55A5A, 7);
        wait_tc(0, b_tc, 400);
        repeat (10) @(negedge clk);
        check("lb_rises", 32'(rises_a - b_r), 32'd32);
        check("lb_latency", 32'(tc_rise_cyc_a - e_cyc), 32'd265);
        check("lb_tc_width", 32'(tc_high_a - b_hi), 32'd2);
        check("lb_rdata", ifa.data_read_from_spi, 32'hA5A55A5A);
        check("lb_mosi", mosi_cap_a, 32'hA5A55A5A);
        check("lb_cs_falls", 32'(cs_falls_a - b_cs), 32'd1);
        check("lb_cs_idle", 32'(ifa.spi_cs_n), 32'd1);

        // MISO tied high, tx = 1
        loop_a = 1'b0; miso_val_a = 1'b1;
        b_r = rises_a; b_tc = tc_rises_a;
        start(0, 32'h00000001, 2);
        wait_tc(0, b_tc, 400);
        repeat (5) @(negedge clk);
        check("m1_rdata", ifa.data_read_from_spi, 32'hFFFFFFFF);
        check("m1_mosi", mosi_cap_a, 32'h00000001);
        check("m1_rises", 32'(rises_a - b_r), 32'd32);
        loop_a = 1'b1;

        // go held high for 600 cycles, then a fresh edge
        b_cs = cs_falls_a; b_tc = tc_rises_a;
        start(0, 32'h00000011, 600);
        repeat (20) @(negedge clk);
        check("hold_cs_falls", 32'(cs_falls_a - b_cs), 32'd1);
        check("hold_tc", 32'(tc_rises_a - b_tc), 32'd1);
        check("hold_rdata", ifa.data_read_from_spi, 32'h00000011);
        start(0, 32'h12345678, 3);
        wait_tc(0, b_tc + 1, 400);
        repeat (5) @(negedge clk);
        check("rego_cs_falls", 32'(cs_falls_a - b_cs), 32'd2);
        check("rego_rdata", ifa.data_read_from_spi, 32'h12345678);

        // Start edge during SHIFT is ignored
        b_r = rises_a; b_cs = cs_falls_a; b_tc = tc_rises_a;
        start(0, 32'h0F0F00FF, 2);
        e1 = e_cyc;
        repeat (100) @(posedge clk);
        start(0, 32'hDEADBEEF, 3);
        wait_tc(0, b_tc, 400);
        repeat (300) @(negedge clk);
        check("busy_tc", 32'(tc_rises_a - b_tc), 32'd1);
        check("busy_latency", 32'(tc_rise_cyc_a - e1), 32'd265);
        check("busy_rdata", ifa.data_read_from_spi, 32'h0F0F00FF);
        check("busy_cs_falls", 32'(cs_falls_a - b_cs), 32'd1);
        check("busy_rises", 32'(rises_a - b_r), 32'd32);

        // Reset at SCLK rise 10
        b_r = rises_a; b_tc = tc_rises_a;
        start(0, 32'hCAFEF00D, 2);
        n = 0;
        while (rises_a - b_r < 10 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("mid_rises", 32'(rises_a - b_r), 32'd10);
        #1 reset_n = 1'b0;
        #1;
        check("mid_cs_n", 32'(ifa.spi_cs_n), 32'd1);
        check("mid_sclk", 32'(ifa.spi_sclk), 32'd0);
        check("mid_rdata", ifa.data_read_from_spi, 32'd0);
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (300) @(negedge clk);
        check("mid_no_tc", 32'(tc_rises_a - b_tc), 32'd0);
        b_r = rises_a;
        start(0, 32'h600DF00D, 2);
        wait_tc(0, b_tc, 400);
        repeat (5) @(negedge clk);
        check("post_rst_rdata", ifa.data_read_from_spi, 32'h600DF00D);
        check("post_rst_rises", 32'(rises_a - b_r), 32'd32);
        check("post_rst_latency", 32'(tc_rise_cyc_a - e_cyc), 32'd265);

        // 8-bit, CLK_DIV=1 loopback
        b_r = rises_b; b_tc = tc_rises_b;
        start(1, 32'h0000003C, 2);
        wait_tc(1, b_tc, 100);
        repeat (5) @(negedge clk);
        check("b_latency", 32'(tc_rise_cyc_b - e_cyc), 32'd19);
        check("b_rdata", 32'(ifb.data_read_from_spi), 32'h3C);
        check("b_rises", 32'(rises_b - b_r), 32'd8);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/spi_master_engine.md
# spi_master_engine

SPI master shift engine sitting behind the Avalon-MM SPI slave bridge. It consumes the bridge's `go_transfer` / `data_write_to_spi` request and runs one full-duplex SPI frame in mode 0 (CPOL=0, CPHA=0), MSB first. It returns the received word on `data_read_from_spi` and signals the end of the frame with a `transfer_complete` pulse. Together with the bridge, this block completes the Avalon-to-SPI path; the engine is the responder end of the go/complete handshake.

## Interface
Parameters:
- `DATA_WIDTH`, 32: frame length in bits. Must be ≥ 2.
- `CLK_DIV`, 4: SCLK half-period in `clk` cycles. Must be ≥ 1.
- `COMPLETE_CYCLES`, 2: width of the `transfer_complete` pulse in `clk` cycles. Must be ≥ 1.

Ports:
- `clk` input 1: system clock. All logic is on the rising edge.
- `reset_n` input 1: one clock; reset is asynchronous and active-low.
- `go_transfer` input 1: start request. Its level may stay high for several cycles; only a 0→1 edge counts.
- `data_write_to_spi` input DATA_WIDTH: transmit word, captured on the accepted start edge.
- `data_read_from_spi` output DATA_WIDTH: last received word. Updated only at frame end.
- `transfer_complete` output 1: end-of-frame pulse, high for COMPLETE_CYCLES cycles.
- `spi_sclk` output 1: SPI clock, idles low.
- `spi_mosi` output 1: serial data out.
- `spi_miso` input 1: serial data in. Treated as synchronous to SCLK; it has no synchronizer.
- `spi_cs_n` output 1: chip select, active low.

## Operation
- Start detection: a registered copy `go_d` is kept. A start means `go_transfer & ~go_d`, evaluated every cycle. A start is accepted only in IDLE; starts seen in any other state are discarded. If `go_transfer` is still high when the engine returns to IDLE, no new frame begins; a fresh 0→1 edge is required.
- State machine:
  - IDLE: `cs_n`=1, `sclk`=0. On an accepted start, latch the tx word into a shift register, clear the receive shift register, drive `mosi` with the tx MSB, and go to SETUP.
  - SETUP: `cs_n`=0 for CLK_DIV cycles, then go to SHIFT.
  - SHIFT: 2·DATA_WIDTH half-periods, indexed h = 0 … 2·DATA_WIDTH−1, each lasting CLK_DIV cycles.
    - `sclk`=0 for even h and 1 for odd h.
    - On entry to each odd h (rising SCLK), shift `spi_miso` into the receive register LSB.
    - On entry to each even h > 0 (falling SCLK), shift the tx register left and drive `mosi` with the new MSB.
    - After the last half-period, force `sclk` to 0 and go to HOLD.
  - HOLD: `cs_n`=0, `sclk`=0 for CLK_DIV cycles, then go to DONE.
  - DONE: `cs_n`=1. Load `data_read_from_spi` from the receive register and hold `transfer_complete`=1 for COMPLETE_CYCLES cycles, then return to IDLE.
- A single down-counter is sized to cover max(CLK_DIV, COMPLETE_CYCLES). The half-period index counter is ⌈log2(2·DATA_WIDTH)⌉ bits wide.
- `mosi` holds the last transmitted bit after the frame. Its value is don't-care while `cs_n`=1, but it must be deterministic.

## Timing
- Reset values: `spi_sclk`=0, `spi_cs_n`=1, `spi_mosi`=0, `data_read_from_spi`=0, `transfer_complete`=0. The state returns to IDLE and `go_d`=0.
- Reset asserted mid-frame: outputs go to reset values immediately (asynchronously). The frame is abandoned, no `transfer_complete` is produced, and `data_read_from_spi` returns to 0.
- Let edge E be the clock edge that samples the start.
  - `cs_n` falls at E+1.
  - The first SCLK rise is at E+1+2·CLK_DIV.
  - `transfer_complete` and `cs_n` rise together at E+1+(2·DATA_WIDTH+2)·CLK_DIV. With defaults this is E+265.
- `data_read_from_spi` changes on the same edge that `transfer_complete` rises and is stable until the next DONE.
- `transfer_complete` falls after exactly COMPLETE_CYCLES cycles. The earliest accepted next start is the first cycle of IDLE after DONE.
- MOSI setup and hold: each bit is stable for CLK_DIV cycles before and after its SCLK rising edge.

## Test plan
- Loopback test (`spi_miso`=`spi_mosi`), defaults, tx 0xA5A55A5A, 7-cycle `go_transfer` pulse:
  - Exactly 32 SCLK rises are observed.
  - `transfer_complete` rises 265 cycles after E and is high for 2 cycles.
  - `data_read_from_spi` = 0xA5A55A5A.
- `spi_miso` tied to 1, tx 0x00000001:
  - MOSI shows 31 zeros then a 1 on the rising edges.
  - `data_read_from_spi` = 0xFFFFFFFF.
- `go_transfer` held high for 600 cycles: exactly one frame runs and no second `cs_n` assertion occurs. Dropping `go_transfer` then re-raising it starts a second frame.
- Start edge pulsed during SHIFT: it is ignored, the frame length is unchanged, and only one `transfer_complete` pulse occurs.
- `reset_n` pulled low at SCLK rise 10:
  - At once `cs_n`=1, `sclk`=0, and `data_read_from_spi`=0.
  - No `transfer_complete` pulse occurs.
  - A subsequent start runs a clean full frame.
- CLK_DIV=1, DATA_WIDTH=8, loopback tx 0x3C:
  - `transfer_complete` rises at E+19.
  - The received value is 0x3C.
